morse_encoder: RTL and testbench
================================

# morse_encoder

Converts one 8-bit ASCII character per handshake into an on/off Morse keying signal with standard unit timing: dot 1, dash 3, element gap 1, letter gap 3, word gap 7. It is the transmit-side counterpart of the Morse decoder. Its `signal` output has the same polarity and meaning as the decoder's `signal` input: 1 = key down. Typical uses are driving an LED/Pmod pin on the ZYBO, or looping back into the decoder for self-test.

## Interface
- `UNIT_CYCLES`, default 12_500_000: clock cycles per Morse unit (100 ms at 125 MHz); legal range ≥1.
- `clk` input 1: system clock, all logic on rising edge.
- `reset` input 1: synchronous, active-high reset.
- `letter` input 8: ASCII character to send; sampled only on accept.
- `valid` input 1: `letter` is presented.
- `ready` output 1: encoder idle and able to accept.
- `signal` output 1: Morse keying output, 1 = mark.
- `done` output 1: one-cycle pulse when a character (including gaps) has finished.
- `err` output 1: one-cycle pulse, coincident with `done`, for an unsupported character.

## Operation
- **Accept.** A character is accepted on any rising edge with `valid && ready`. `letter` is ignored otherwise.
- **Lookup.** On accept, `letter` is mapped to an element pattern (≤5 elements, 1 = dash, sent MSB-first) and a 3-bit length.
  - 'A'–'Z' (0x41–0x5A) use ITU patterns.
  - 'a'–'z' map to the same patterns as uppercase.
  - ' ' (0x20) is a word space.
- **States.**
  - IDLE: `ready`=1, `signal`=0. Accept of a letter goes to MARK; accept of a space goes to WORD_GAP; accept of an unsupported character stays in IDLE and pulses `done`+`err` the next cycle.
  - MARK: `signal`=1 for 1 unit (dot) or 3 units (dash). If elements remain, go to ELEM_GAP, else go to LETTER_GAP.
  - ELEM_GAP: `signal`=0 for 1 unit, then MARK for the next element.
  - LETTER_GAP: `signal`=0 for 3 units, then IDLE with `done`=1.
  - WORD_GAP: `signal`=0 for 4 units, then IDLE with `done`=1. This 4 plus the preceding letter's 3 gives 7.
- **Unit counter.** Width `$clog2(UNIT_CYCLES*3)`, reloaded on every state entry; no wrap beyond the terminal count.
- **Reset.** Reset asserted in any state: next edge goes to IDLE; `signal`=0, `ready`=1, `done`=0, `err`=0; pattern and counters are cleared. An in-flight character is discarded, with no `done`.
- **`valid` while busy.** Has no effect; the source must hold `letter` until `ready`.

## Timing
- **Reset values:** `ready`=1, `signal`=0, `done`=0, `err`=0.
- **Latency:** accept at edge 0, so `signal` rises in cycle 1 (registered output, no combinational path from `letter`).
- **Mark/gap widths:** each mark/gap lasts exactly N×`UNIT_CYCLES` cycles, with no extra bubble cycles between states.
- **`done`:** high exactly in the first IDLE cycle, in which `ready`=1. A new character can be accepted in that same cycle, giving back-to-back characters with no dead cycle.
- **Unsupported character:** `done`=`err`=1 in cycle 1; `ready` stays 1 throughout; `signal` never rises.
- **Output stability:** `ready` deasserts the cycle after accept and stays low until `done`.

## Configuration
- `MORSE_DIGITS_EN` defined: '0'–'9' (0x30–0x39) are encoded as 5-element ITU patterns.
- `MORSE_DIGITS_EN` undefined: digits are unsupported (`err` path); the table and the 5th pattern bit may be trimmed to 4 elements.

## Test plan
All scenarios use `UNIT_CYCLES`=2; accept is at edge 0.
- **'E' (0x45):** `signal`=1 in cycles 1–2 and 0 in cycles 3–8; `done`=1, `ready`=1 in cycle 9; `err`=0.
- **'A' (0x41), then 'a' (0x61) in the `done` cycle:** `signal` high 1–2, low 3–4, high 5–10, low 11–16; `done` at 17. The second character is accepted at 17 and repeats the identical waveform offset by 17 cycles.
- **' ' (0x20):** `signal` low for cycles 1–8; `done` at 9. **'#' (0x23):** `done`=`err`=1 in cycle 1, `signal` stays 0, `ready` never drops.
- **'5' (0x35):**
  - With `MORSE_DIGITS_EN`: highs at 1–2, 5–6, 9–10, 13–14, 17–18; `done` at 25.
  - Without the macro: `err` at cycle 1.
- **Reset mid-character:** send 'T' (0x54, dash), assert `reset` at cycle 3. Cycle 4: `signal`=0, `ready`=1, no `done`. A subsequent 'E' then behaves exactly as in the first scenario.

Source files
------------

// File: rtl/morse_encoder.sv
// morse_encoder: turns one ASCII character per valid/ready handshake into an
// on/off Morse keying signal (dot 1 unit, dash 3, element gap 1, letter gap 3,
// word gap 4 after the letter gap for a total of 7).
// Optional feature macro: MORSE_DIGITS_EN enables '0'-'9' as 5-element codes;
// without it digits take the unsupported-character path and patterns are
// only 4 elements wide.
module morse_encoder #(
    parameter int UNIT_CYCLES = 12_500_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] letter,
    input  logic       valid,
    output logic       ready,
    output logic       signal,
    output logic       done,
    output logic       err
);

    localparam int CNT_W = $clog2(UNIT_CYCLES * 3);
`ifdef MORSE_DIGITS_EN
    localparam int PAT_W = 5;
`else
    localparam int PAT_W = 4;
`endif

    // Counter reload values: the counter runs down to zero, so N units
    // load N*UNIT_CYCLES-1. The 4-unit word gap is split into 3+1 units so
    // the reload never exceeds the 3-unit terminal count.
    localparam logic [CNT_W-1:0] LOAD_1 = CNT_W'(UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOAD_3 = CNT_W'(3 * UNIT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MARK,
        S_ELEM_GAP,
        S_LETTER_GAP,
        S_WORD_GAP
    } state_t;

    // Letter table, index 0 = 'A'. Returns {length[2:0], pattern[3:0]} with
    // the pattern left-aligned (first element in bit 3, 1 = dash).
    function automatic logic [6:0] letter_code(input logic [4:0] idx);
        logic [6:0] code;
        case (idx)
            5'd0:    code = {3'd2, 4'b0100}; // A .-
            5'd1:    code = {3'd4, 4'b1000}; // B -...
            5'd2:    code = {3'd4, 4'b1010}; // C -.-.
            5'd3:    code = {3'd3, 4'b1000}; // D -..
            5'd4:    code = {3'd1, 4'b0000}; // E .
            5'd5:    code = {3'd4, 4'b0010}; // F ..-.
            5'd6:    code = {3'd3, 4'b1100}; // G --.
            5'd7:    code = {3'd4, 4'b0000}; // H ....
            5'd8:    code = {3'd2, 4'b0000}; // I ..
            5'd9:    code = {3'd4, 4'b0111}; // J .---
            5'd10:   code = {3'd3, 4'b1010}; // K -.-
            5'd11:   code = {3'd4, 4'b0100}; // L .-..
            5'd12:   code = {3'd2, 4'b1100}; // M --
            5'd13:   code = {3'd2, 4'b1000}; // N -.
            5'd14:   code = {3'd3, 4'b1110}; // O ---
            5'd15:   code = {3'd4, 4'b0110}; // P .--.
            5'd16:   code = {3'd4, 4'b1101}; // Q --.-
            5'd17:   code = {3'd3, 4'b0100}; // R .-.
            5'd18:   code = {3'd3, 4'b0000}; // S ...
            5'd19:   code = {3'd1, 4'b1000}; // T -
            5'd20:   code = {3'd3, 4'b0010}; // U ..-
            5'd21:   code = {3'd4, 4'b0001}; // V ...-
            5'd22:   code = {3'd3, 4'b0110}; // W .--
            5'd23:   code = {3'd4, 4'b1001}; // X -..-
            5'd24:   code = {3'd4, 4'b1011}; // Y -.--
            5'd25:   code = {3'd4, 4'b1100}; // Z --..
            default: code = 7'd0;
        endcase
        return code;
    endfunction

`ifdef MORSE_DIGITS_EN
    // Digit table, index 0 = '0'; all digits are exactly 5 elements.
    function automatic logic [4:0] digit_code(input logic [3:0] idx);
        logic [4:0] code;
        case (idx)
            4'd0:    code = 5'b11111;
            4'd1:    code = 5'b01111;
            4'd2:    code = 5'b00111;
            4'd3:    code = 5'b00011;
            4'd4:    code = 5'b00001;
            4'd5:    code = 5'b00000;
            4'd6:    code = 5'b10000;
            4'd7:    code = 5'b11000;
            4'd8:    code = 5'b11100;
            4'd9:    code = 5'b11110;
            default: code = 5'b00000;
        endcase
        return code;
    endfunction
`endif

    state_t             r_state;
    logic [CNT_W-1:0]   r_count;
    logic [PAT_W-1:0]   r_pattern;
    logic [2:0]         r_remain;
    logic               r_word_tail;
    logic               r_ready;
    logic               r_signal;
    logic               r_done;
    logic               r_err;

    logic [7:0]         w_upper;
    logic [6:0]         w_code;
    logic               w_supported;
    logic               w_space;
    logic [2:0]         w_len;
    logic [PAT_W-1:0]   w_pat;
    logic               w_count_end;

    assign w_count_end = (r_count == '0);

    // Decode the presented character into pattern, length and class.
    always_comb begin
        w_upper     = letter;
        w_code      = 7'd0;
        w_supported = 1'b0;
        w_space     = 1'b0;
        w_len       = 3'd0;
        w_pat       = '0;
        if (letter >= 8'h61 && letter <= 8'h7A) begin
            w_upper = letter - 8'h20;
        end
        if (letter == 8'h20) begin
            w_supported = 1'b1;
            w_space     = 1'b1;
        end else if (w_upper >= 8'h41 && w_upper <= 8'h5A) begin
            w_code      = letter_code(5'(w_upper - 8'h41));
            w_supported = 1'b1;
            w_len       = w_code[6:4];
`ifdef MORSE_DIGITS_EN
            w_pat       = {w_code[3:0], 1'b0};
`else
            w_pat       = w_code[3:0];
`endif
        end
`ifdef MORSE_DIGITS_EN
        else if (letter >= 8'h30 && letter <= 8'h39) begin
            w_supported = 1'b1;
            w_len       = 3'd5;
            w_pat       = digit_code(4'(letter - 8'h30));
        end
`endif
    end

    // Keying FSM: all outputs registered, counter reloaded on each state entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_pattern   <= '0;
            r_remain    <= 3'd0;
            r_word_tail <= 1'b0;
            r_ready     <= 1'b1;
            r_signal    <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (valid && r_ready) begin
                        if (!w_supported) begin
                            r_done <= 1'b1;
                            r_err  <= 1'b1;
                        end else if (w_space) begin
                            r_state     <= S_WORD_GAP;
                            r_count     <= LOAD_3;
                            r_word_tail <= 1'b0;
                            r_ready     <= 1'b0;
                        end else begin
                            r_state   <= S_MARK;
                            r_signal  <= 1'b1;
                            r_ready   <= 1'b0;
                            r_count   <= w_pat[PAT_W-1] ? LOAD_3 : LOAD_1;
                            r_pattern <= w_pat << 1;
                            r_remain  <= w_len - 3'd1;
                        end
                    end
                end
                S_MARK: begin
                    if (w_count_end) begin
                        r_signal <= 1'b0;
                        if (r_remain != 3'd0) begin
                            r_state <= S_ELEM_GAP;
                            r_count <= LOAD_1;
                        end else begin
                            r_state <= S_LETTER_GAP;
                            r_count <= LOAD_3;
                        end
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
                S_ELEM_GAP: begin
                    if (w_count_end) begin
                        r_state   <= S_MARK;
                        r_signal  <= 1'b1;
                        r_count   <= r_pattern[PAT_W-1] ? LOAD_3 : LOAD_1;
                        r_pattern <= r_pattern << 1;
                        r_remain  <= r_remain - 3'd1;
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
                S_LETTER_GAP: begin
                    if (w_count_end) begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                        r_done  <= 1'b1;
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
                S_WORD_GAP: begin
                    if (w_count_end) begin
                        if (!r_word_tail) begin
                            r_count     <= LOAD_1;
                            r_word_tail <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                            r_ready <= 1'b1;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_ready  <= 1'b1;
                    r_signal <= 1'b0;
                end
            endcase
        end
    end

    assign ready  = r_ready;
    assign signal = r_signal;
    assign done   = r_done;
    assign err    = r_err;

endmodule

// File: tb/tb_morse_encoder.sv
// Testbench for morse_encoder with UNIT_CYCLES = 2. Each accepted character
// pushes its expected per-cycle {signal, ready, done, err} waveform onto a
// scoreboard queue; a negedge monitor pops one entry per cycle and compares,
// expecting the idle pattern whenever the queue is empty.
module tb_morse_encoder;

    localparam int U = 2;

    logic       clk;
    logic       reset;
    logic [7:0] letter;
    logic       valid;
    logic       ready;
    logic       signal;
    logic       done;
    logic       err;

    int n_checks = 0;
    int n_pass   = 0;
    logic       mon_en = 1'b0;
    logic [3:0] exp_q[$];
    logic [3:0] mon_exp;
    int         cyc = 0;

    morse_encoder #(.UNIT_CYCLES(U)) dut (
        .clk    (clk),
        .reset  (reset),
        .letter (letter),
        .valid  (valid),
        .ready  (ready),
        .signal (signal),
        .done   (done),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference Morse strings; " " marks a word space, "?" unsupported.
    function automatic string morse_of(input logic [7:0] c);
        logic [7:0] u;
        u = c;
        if (c >= 8'h61 && c <= 8'h7A) u = c - 8'h20;
        case (u)
            8'h20: return " ";
            "A": return ".-";    "B": return "-...";  "C": return "-.-.";
            "D": return "-..";   "E": return ".";     "F": return "..-.";
            "G": return "--.";   "H": return "....";  "I": return "..";
            "J": return ".---";  "K": return "-.-";   "L": return ".-..";
            "M": return "--";    "N": return "-.";    "O": return "---";
            "P": return ".--.";  "Q": return "--.-";  "R": return ".-.";
            "S": return "...";   "T": return "-";     "U": return "..-";
            "V": return "...-";  "W": return ".--";   "X": return "-..-";
            "Y": return "-.--";  "Z": return "--..";
`ifdef MORSE_DIGITS_EN
            "0": return "-----"; "1": return ".----"; "2": return "..---";
            "3": return "...--"; "4": return "....-"; "5": return ".....";
            "6": return "-...."; "7": return "--..."; "8": return "---..";
            "9": return "----.";
`endif
            default: return "?";
        endcase
    endfunction

    // Push the expected waveform for cycles 1.. after accept (keep>0 truncates).
    task automatic push_char(input logic [7:0] c, input int keep);
        logic [3:0] seq[$];
        string m;
        m = morse_of(c);
        if (m == "?") begin
            seq.push_back(4'b0111);
        end else if (m == " ") begin
            repeat (4 * U) seq.push_back(4'b0000);
            seq.push_back(4'b0110);
        end else begin
            for (int i = 0; i < m.len(); i++) begin
                repeat ((m[i] == 8'h2D) ? 3 * U : U) seq.push_back(4'b1000);
                if (i < m.len() - 1) repeat (U) seq.push_back(4'b0000);
            end
            repeat (3 * U) seq.push_back(4'b0000);
            seq.push_back(4'b0110);
        end
        if (keep > 0) while (seq.size() > keep) void'(seq.pop_back());
        $display("send 0x%02h code '%s' expecting %0d cycles", c, m, seq.size());
        foreach (seq[i]) exp_q.push_back(seq[i]);
    endtask

    // Present a character for one cycle (the accept cycle) and queue its waveform.
    task automatic send(input logic [7:0] c, input int keep);
        if (exp_q.size() == 0) exp_q.push_back(4'b0100);
        letter = c;
        valid  = 1'b1;
        push_char(c, keep);
        step();
        valid  = 1'b0;
        letter = 8'h00;
    endtask

    // Advance until at most 'target' scoreboard entries remain.
    task automatic wait_q(input int target);
        int n;
        n = 0;
        while (exp_q.size() > target && n < 500) begin
            step();
            n++;
        end
        if (exp_q.size() > target) check("drain_timeout", 32'(exp_q.size()), 32'(target));
    endtask

    // Per-cycle monitor comparing DUT outputs to the scoreboard.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (mon_en) begin
            if (exp_q.size() > 0) mon_exp = exp_q.pop_front();
            else                  mon_exp = 4'b0100;
            check($sformatf("cyc%0d {sig,rdy,done,err}", cyc),
                  32'({signal, ready, done, err}), 32'(mon_exp));
        end
    end

    initial begin
        reset  = 1'b1;
        valid  = 1'b0;
        letter = 8'h00;
        repeat (3) step();
        check("rst_signal", 32'(signal), 32'd0);
        check("rst_ready",  32'(ready),  32'd1);
        check("rst_done",   32'(done),   32'd0);
        check("rst_err",    32'(err),    32'd0);
        reset = 1'b0;
        step();
        mon_en = 1'b1;
        step();

        // Single dot
        send(8'h45, 0);
        wait_q(0);
        step();

        // 'A' then 'a' accepted in the done cycle (back-to-back)
        send(8'h41, 0);
        wait_q(1);
        send(8'h61, 0);
        wait_q(0);
        step();

        // Word space, then unsupported character
        send(8'h20, 0);
        wait_q(0);
        send(8'h23, 0);
        wait_q(0);
        step();

        // Digit: 5 dots with the feature, err path without it
        send(8'h35, 0);
        wait_q(0);
        step();

        // valid held while busy must be ignored
        send(8'h4D, 0);
        letter = 8'h45;
        valid  = 1'b1;
        repeat (3) step();
        valid  = 1'b0;
        wait_q(0);
        step();

        // Reset in the middle of a dash: only cycles 1-3 are marked
        send(8'h54, 3);
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (2) step();

        // Same 'E' waveform after the reset
        send(8'h45, 0);
        wait_q(0);

        // Lowercase letter with mixed elements
        send(8'h71, 0);
        wait_q(0);
        repeat (3) step();

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
